servo_ramp_ctrl: RTL
====================

SERVO_RAMP_CTRL -- requirements
Module: servo_ramp_ctrl

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 25_000_000, system clock frequency.
REQ-002 Parameter FRAME_CLKS, default 500_000, PWM frame length in clocks (20 ms).
REQ-003 Parameter PULSE_DOWN_CLKS, default 25_000, pulse width for flag down (0 deg, 1 ms).
REQ-004 Parameter PULSE_UP_CLKS, default 37_500, pulse width for flag up (90 deg, 1.5 ms).
REQ-005 Parameter STEP_CLKS, default 625, maximum pulse-width change per frame.
REQ-006 Parameter SETTLE_FRAMES, default 10, frames held at target before done.
REQ-007 clk  in  1  system clock, 25 MHz; the block's only clock.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 cmd_valid  in  1  request to move the flag.
REQ-010 cmd_pos  in  1  requested position: 1 = up, 0 = down; sampled with cmd_valid.
REQ-011 cmd_ready  out  1  high when a command can be accepted.
REQ-012 frame_start  out  1  one-cycle pulse at the first clock of every PWM frame.
REQ-013 pulse_clks  out  19  current pulse width in clocks, fed to the PWM comparator.
REQ-014 busy  out  1  high while in RAMP or SETTLE.
REQ-015 done  out  1  one-cycle pulse when SETTLE completes.

Function
REQ-016 The frame counter shall count 0..FRAME_CLKS-1 and wrap; frame_start is high when the count is 0.
REQ-017 The FSM shall have states IDLE, RAMP and SETTLE; cmd_ready equals (state == IDLE).
REQ-018 In IDLE, cmd_valid=1 shall accept the command: latch target = cmd_pos ? PULSE_UP_CLKS : PULSE_DOWN_CLKS and go to RAMP on the next cycle.
REQ-019 cmd_valid while busy shall be ignored with no side effect.
REQ-020 pulse_clks shall change only in the cycle after a frame_start, so a PWM frame never sees a mid-frame width change.
REQ-021 In RAMP, on each frame_start pulse_clks shall move toward target by STEP_CLKS, clamped to exactly target (no overshoot).
REQ-022 RAMP shall go to SETTLE when pulse_clks equals target; a command equal to the current pulse_clks enters SETTLE with zero ramp frames.
REQ-023 A frame_start in the same cycle as command acceptance shall not apply a step; the first step occurs at the following frame_start.
REQ-024 SETTLE shall count SETTLE_FRAMES frame_start pulses, then pulse done for one cycle and return to IDLE.
REQ-025 Default ramp up or down shall take 20 frames (400 ms), and SETTLE a further 10 frames.
REQ-026 pulse_clks arithmetic shall be unsigned 19-bit and must never leave [PULSE_DOWN_CLKS, PULSE_UP_CLKS].

Reset
REQ-027 While reset is sampled high: state = IDLE, frame count = 0, pulse_clks = PULSE_DOWN_CLKS, target = PULSE_DOWN_CLKS, busy = 0, done = 0, frame_start = 0.
REQ-028 cmd_ready shall be 0 during reset and 1 in the first cycle after reset deasserts.
REQ-029 Reset mid-ramp shall abandon the move and set the flag to down; no done pulse is generated.

Configuration
REQ-030 Macro SERVO_RAMP_EN defined: ramped motion per REQ-021.
REQ-031 Macro SERVO_RAMP_EN undefined: at the first frame_start in RAMP, pulse_clks shall jump to target; the STEP_CLKS parameter is unused, and SETTLE is unchanged.

Structure
REQ-032 Package servo_pkg shall hold the state enum and the default constants: CLK_FREQ_HZ, FRAME_CLKS, PULSE_DOWN_CLKS, PULSE_UP_CLKS, STEP_CLKS and SETTLE_FRAMES.
REQ-033 The frame counter shall be a sub-module servo_frame_timer with outputs frame_start and the count.

Verification
REQ-034 Reset release, no command -> pulse_clks = 25000, cmd_ready = 1, frame_start every 500000 clocks.
REQ-035 Up command with ramp enabled -> pulse_clks = 25625 after the first following frame_start, 37500 after 20 frames, and done 10 frames later.
REQ-036 Second cmd_valid during RAMP -> ignored; target and timing are identical to the single-command run.
REQ-037 Down command while at 25000 -> no ramp; done after exactly 10 frames.
REQ-038 Reset asserted at frame 7 of an up ramp -> pulse_clks = 25000 the next cycle and no done pulse.
REQ-039 SERVO_RAMP_EN undefined, up command -> pulse_clks = 37500 after the first frame_start, and done 10 frames later.

Source files
------------

// File: rtl/servo_pkg.sv
// -----------------------------------------------------------------------------
// servo_pkg
// Shared types and default constants for the servo ramp controller.
//   state_e      : controller FSM states
//   PULSE_W      : width of the pulse-width datapath (19 bits)
//   step_toward(): move a pulse width toward a target by at most one step
// -----------------------------------------------------------------------------
package servo_pkg;

  localparam int unsigned CLK_FREQ_HZ     = 25_000_000;
  localparam int unsigned FRAME_CLKS      = 500_000;   // 20 ms frame
  localparam int unsigned PULSE_DOWN_CLKS = 25_000;    // 1.0 ms, flag down
  localparam int unsigned PULSE_UP_CLKS   = 37_500;    // 1.5 ms, flag up
  localparam int unsigned STEP_CLKS       = 625;       // max change per frame
  localparam int unsigned SETTLE_FRAMES   = 10;

  localparam int unsigned PULSE_W = 19;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RAMP,
    ST_SETTLE
  } state_e;

  // Differences are taken only in the direction that cannot underflow, and the
  // add is taken only when it stays below the target, so no wrap is possible.
  function automatic logic [PULSE_W-1:0] step_toward(
    input logic [PULSE_W-1:0] cur,
    input logic [PULSE_W-1:0] tgt,
    input logic [PULSE_W-1:0] step
  );
    if (cur < tgt) begin
      return ((tgt - cur) > step) ? cur + step : tgt;
    end else if (cur > tgt) begin
      return ((cur - tgt) > step) ? cur - step : tgt;
    end
    return cur;
  endfunction

endpackage

// File: rtl/servo_ramp_ctrl_if.sv
// -----------------------------------------------------------------------------
// servo_ramp_ctrl_if
// Command handshake and status bundle of the servo ramp controller.
//   cmd_valid/cmd_pos/cmd_ready : move request (1 = up, 0 = down)
//   frame_start                 : first clock of each PWM frame
//   pulse_clks                  : current pulse width for the PWM comparator
//   busy/done                   : move in progress / settle complete pulse
// master = command issuer, slave = controller.
// -----------------------------------------------------------------------------
interface servo_ramp_ctrl_if;
  import servo_pkg::*;

  logic               cmd_valid;
  logic               cmd_pos;
  logic               cmd_ready;
  logic               frame_start;
  logic [PULSE_W-1:0] pulse_clks;
  logic               busy;
  logic               done;

  modport master (
    output cmd_valid, cmd_pos,
    input  cmd_ready, frame_start, pulse_clks, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_pos,
    output cmd_ready, frame_start, pulse_clks, busy, done
  );
endinterface

// File: rtl/servo_frame_timer.sv
// -----------------------------------------------------------------------------
// servo_frame_timer
// Free-running PWM frame counter, 0..FRAME_CLKS-1 then wrap.
//   clk, reset    : clock, synchronous active-high reset
//   frame_start_o : high while the count is 0 (suppressed during reset)
//   count_o       : current position within the frame
// -----------------------------------------------------------------------------
module servo_frame_timer #(
  parameter int unsigned FRAME_CLKS = servo_pkg::FRAME_CLKS,
  parameter int unsigned CNT_W      = $clog2(FRAME_CLKS)
) (
  input  logic             clk,
  input  logic             reset,
  output logic             frame_start_o,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_CLKS - 1);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; reset is synchronous, so it lives inside the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign frame_start_o = (cnt_q == '0) && !reset;
  assign count_o       = cnt_q;

endmodule

// File: rtl/servo_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// servo_ramp_ctrl
// Drives a hobby-servo flag between down (PULSE_DOWN_CLKS) and up
// (PULSE_UP_CLKS). Width updates are applied only on frame boundaries, then
// the controller holds the target for SETTLE_FRAMES frames and pulses done.
//   clk, reset : clock, synchronous active-high reset
//   bus        : servo_ramp_ctrl_if.slave (command handshake + status)
// Build option: define SERVO_RAMP_EN to ramp by STEP_CLKS per frame; when it
// is undefined the width jumps to the target at the first frame in RAMP.
// -----------------------------------------------------------------------------
module servo_ramp_ctrl
  import servo_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ     = servo_pkg::CLK_FREQ_HZ,
  parameter int unsigned FRAME_CLKS      = servo_pkg::FRAME_CLKS,
  parameter int unsigned PULSE_DOWN_CLKS = servo_pkg::PULSE_DOWN_CLKS,
  parameter int unsigned PULSE_UP_CLKS   = servo_pkg::PULSE_UP_CLKS,
  parameter int unsigned STEP_CLKS       = servo_pkg::STEP_CLKS,
  parameter int unsigned SETTLE_FRAMES   = servo_pkg::SETTLE_FRAMES
) (
  input logic              clk,
  input logic              reset,
  servo_ramp_ctrl_if.slave bus
);

  localparam int unsigned FRAME_W  = $clog2(FRAME_CLKS);
  localparam int unsigned SETTLE_W = $clog2(SETTLE_FRAMES + 1);

  localparam logic [PULSE_W-1:0]  DOWN_W      = PULSE_W'(PULSE_DOWN_CLKS);
  localparam logic [PULSE_W-1:0]  UP_W        = PULSE_W'(PULSE_UP_CLKS);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_FRAMES - 1);
`ifdef SERVO_RAMP_EN
  localparam logic [PULSE_W-1:0]  STEP_W      = PULSE_W'(STEP_CLKS);
`endif

  logic               frame_start;
  logic [FRAME_W-1:0] frame_cnt;

  state_e              state_q,  state_d;
  logic [PULSE_W-1:0]  pulse_q,  pulse_d;
  logic [PULSE_W-1:0]  target_q, target_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic                done_c;

  servo_frame_timer #(
    .FRAME_CLKS (FRAME_CLKS)
  ) u_frame_timer (
    .clk           (clk),
    .reset         (reset),
    .frame_start_o (frame_start),
    .count_o       (frame_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      pulse_q  <= DOWN_W;
      target_q <= DOWN_W;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      pulse_q  <= pulse_d;
      target_q <= target_d;
      settle_q <= settle_d;
    end
  end

  // NOTE: every signal written here gets its hold value first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    pulse_d  = pulse_q;
    target_d = target_q;
    settle_d = settle_q;
    done_c   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // A frame_start coinciding with acceptance is not a step: stepping
        // happens only in RAMP, which starts the following cycle.
        if (bus.cmd_valid) begin
          target_d = bus.cmd_pos ? UP_W : DOWN_W;
          state_d  = ST_RAMP;
        end
      end

      ST_RAMP: begin
        // Checking arrival before stepping also covers a command equal to the
        // current width: it leaves RAMP without waiting for a frame.
        if (pulse_q == target_q) begin
          state_d  = ST_SETTLE;
          settle_d = '0;
        end else if (frame_start) begin
`ifdef SERVO_RAMP_EN
          pulse_d = step_toward(pulse_q, target_q, STEP_W);
`else
          pulse_d = target_q;
`endif
        end
      end

      ST_SETTLE: begin
        if (frame_start) begin
          if (settle_q == SETTLE_LAST) begin
            done_c  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            settle_d = settle_q + 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Status is forced inactive while reset is sampled, before the state
  // register has had an edge to clear.
  assign bus.cmd_ready   = (state_q == ST_IDLE) && !reset;
  assign bus.busy        = (state_q != ST_IDLE) && !reset;
  assign bus.done        = done_c && !reset;
  assign bus.frame_start = frame_start;
  assign bus.pulse_clks  = pulse_q;

endmodule
